// File: rtl/sonic_tx_ready_ctl_mc_pkg.sv
// sonic_tx_ctl_pkg: shared FSM state type, default watermarks and the load clamp helper.
package sonic_tx_ctl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} tx_ready_state_t;
  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned DEF_WIDTH = 14;
  localparam int unsigned DEF_START_THRESH = 32'h200;
  localparam int unsigned DEF_STOP_THRESH = 0;
  localparam int unsigned DEF_MAX_QWORDS = 32'h3E00;
  function automatic int unsigned clamp_u(input int unsigned v, input int unsigned m);
    return v > m ? m : v;
  endfunction
endpackage

// File: rtl/sonic_tx_ready_ctl_mc_if.sv
// sonic_tx_ready_ctl_mc_if: per-channel vector bundle between completion/usedw logic and the TX gate.
interface sonic_tx_ready_ctl_mc_if
  import sonic_tx_ctl_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic [NUM_CH-1:0] tag_cpl;
  logic [NUM_CH*WIDTH-1:0] rdusedqwords;
  logic [NUM_CH-1:0] rdreq;
  logic [NUM_CH-1:0] rdena;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] flush;
  logic [NUM_CH-1:0] gearbox_ena;
  logic [NUM_CH-1:0] cbuf_rdreq;
  logic [NUM_CH-1:0] cbuf_rdena;
  logic [NUM_CH*WIDTH-1:0] cpld_count;
  logic [NUM_CH-1:0] underrun;
  modport master (
    output tag_cpl, rdusedqwords, rdreq, rdena, empty, flush,
    input gearbox_ena, cbuf_rdreq, cbuf_rdena, cpld_count, underrun
  );
  modport slave (
    input tag_cpl, rdusedqwords, rdreq, rdena, empty, flush,
    output gearbox_ena, cbuf_rdreq, cbuf_rdena, cpld_count, underrun
  );
endinterface

// File: rtl/sonic_tx_ready_ctl_mc_ch.sv
// sonic_tx_ready_ch: one channel's qword count, IDLE/RUN/DRAIN gearbox gate and underrun flag.
// SONIC_TX_UNDERRUN_EN compiles in the sticky underrun flop; otherwise underrun is tied to 0.
module sonic_tx_ready_ch
  import sonic_tx_ctl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned START_THRESH = DEF_START_THRESH,
  parameter int unsigned STOP_THRESH = DEF_STOP_THRESH,
  parameter int unsigned MAX_QWORDS = DEF_MAX_QWORDS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tag_cpl,
  input  logic [WIDTH-1:0] rdusedqwords,
  input  logic             rdreq,
  input  logic             rdena,
  input  logic             empty,
  input  logic             flush,
  output logic             gearbox_ena,
  output logic             cbuf_rdreq,
  output logic             cbuf_rdena,
  output logic [WIDTH-1:0] cpld_count,
  output logic             underrun
);
  localparam logic [WIDTH-1:0] START = WIDTH'(START_THRESH);
  localparam logic [WIDTH-1:0] STOP = WIDTH'(STOP_THRESH);
  localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MAX_QWORDS);
  tx_ready_state_t state;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] load_adj;
  logic [WIDTH-1:0] count_nxt;
  assign gearbox_ena = state != IDLE;
  assign cbuf_rdreq = rdreq & gearbox_ena & ~empty;
  assign cbuf_rdena = rdena & gearbox_ena;
  // A read accepted alongside a load consumes one qword of the fresh value.
  always_comb begin
    load = WIDTH'(clamp_u(32'(rdusedqwords), 32'(MAXQ)));
    load_adj = load - WIDTH'(cbuf_rdreq && load != '0);
    count_nxt = (state == IDLE && flush) ? '0 :
                (tag_cpl && state != DRAIN) ? load_adj :
                cbuf_rdreq ? cpld_count - WIDTH'(cpld_count != '0) : cpld_count;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cpld_count <= '0;
    end else begin
      cpld_count <= count_nxt;
      case (state)
        IDLE:    state <= (!flush && cpld_count >= START) ? RUN : IDLE;
        RUN:     state <= flush ? DRAIN : (cpld_count <= STOP) ? IDLE : RUN;
        DRAIN:   state <= (cpld_count == '0) ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
`ifdef SONIC_TX_UNDERRUN_EN
  // Set beats clear so an underrun coinciding with flush is not lost.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) underrun <= 1'b0;
    else underrun <= (rdreq & gearbox_ena & empty) | (underrun & ~flush);
`else
  assign underrun = 1'b0;
`endif
endmodule

// File: rtl/sonic_tx_ready_ctl_mc.sv
// sonic_tx_ready_ctl_mc: NUM_CH independent TX readiness gates over a shared vector bundle.
// Optional SONIC_TX_UNDERRUN_EN enables the per-channel sticky underrun flag.
module sonic_tx_ready_ctl_mc
  import sonic_tx_ctl_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned START_THRESH = DEF_START_THRESH,
  parameter int unsigned STOP_THRESH = DEF_STOP_THRESH,
  parameter int unsigned MAX_QWORDS = DEF_MAX_QWORDS
) (
  input logic clock,
  input logic reset_n,
  sonic_tx_ready_ctl_mc_if.slave bus
);
  logic [NUM_CH-1:0] ena;
  logic [NUM_CH-1:0] rq;
  logic [NUM_CH-1:0] re;
  logic [NUM_CH-1:0] ur;
  logic [NUM_CH*WIDTH-1:0] cnt;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sonic_tx_ready_ch #(
      .WIDTH(WIDTH),
      .START_THRESH(START_THRESH),
      .STOP_THRESH(STOP_THRESH),
      .MAX_QWORDS(MAX_QWORDS)
    ) u_ch (
      .clock(clock),
      .reset_n(reset_n),
      .tag_cpl(bus.tag_cpl[i]),
      .rdusedqwords(bus.rdusedqwords[i*WIDTH +: WIDTH]),
      .rdreq(bus.rdreq[i]),
      .rdena(bus.rdena[i]),
      .empty(bus.empty[i]),
      .flush(bus.flush[i]),
      .gearbox_ena(ena[i]),
      .cbuf_rdreq(rq[i]),
      .cbuf_rdena(re[i]),
      .cpld_count(cnt[i*WIDTH +: WIDTH]),
      .underrun(ur[i])
    );
  end
  assign bus.gearbox_ena = ena;
  assign bus.cbuf_rdreq = rq;
  assign bus.cbuf_rdena = re;
  assign bus.cpld_count = cnt;
  assign bus.underrun = ur;
endmodule

// File: doc/sonic_tx_ready_ctl_mc.md
# sonic_tx_ready_ctl_mc

Multi-channel, parametrised TX readiness controller that gates the 66-bit gearboxes of up to `NUM_CH` SFP lanes from per-channel completed-qword counts. It sits in the read (SFP) clock domain between the per-channel completion-tag crossers, the usedw calculators and the TX circular buffers. It generalises start/stop hysteresis into configurable watermarks, and adds:
- a controlled flush/drain mode,
- load clamping,
- sticky underrun detection.

## Interface
Parameters:
- `NUM_CH`, 2: number of independent TX channels.
- `WIDTH`, 14: width of the qword count.
- `START_THRESH`, 14'h200: the channel count at or above which the gearbox is enabled.
- `STOP_THRESH`, 0: the channel count at or below which a running channel stops. Must be less than `START_THRESH`.
- `MAX_QWORDS`, 14'h3E00: clamp value for loaded counts.

Ports:
- `clock`  in  1  read-domain clock. One clock only.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tag_cpl`  in  NUM_CH  per-channel completion pulse, already clock-crossed.
- `rdusedqwords`  in  NUM_CH*WIDTH  per-channel used-qword count from the usedw calculator. Channel i occupies bits [i*WIDTH +: WIDTH].
- `rdreq`  in  NUM_CH  gearbox read request.
- `rdena`  in  NUM_CH  SFP/TX enable.
- `empty`  in  NUM_CH  circular buffer empty.
- `flush`  in  NUM_CH  one-cycle pulse requesting drain-to-zero.
- `gearbox_ena`  out  NUM_CH  gearbox enable.
- `cbuf_rdreq`  out  NUM_CH  accepted read to the circular buffer.
- `cbuf_rdena`  out  NUM_CH  circular buffer read enable.
- `cpld_count`  out  NUM_CH*WIDTH  completed-qword count.
- `underrun`  out  NUM_CH  sticky underrun flag.

## Operation
- Each channel is fully independent. There is no cross-channel arbitration.
- Per-channel FSM states: IDLE, RUN, DRAIN. `gearbox_ena[i]` = (state is RUN or DRAIN).
- Combinational read signals:
  - `cbuf_rdreq[i]` = `rdreq[i]` & `gearbox_ena[i]` & ~`empty[i]`.
  - `cbuf_rdena[i]` = `rdena[i]` & `gearbox_ena[i]`.
- Count update, in priority order:
  1. If `tag_cpl` is high and the state is not DRAIN, load L = min(`rdusedqwords`, `MAX_QWORDS`), minus 1 if `cbuf_rdreq` is high and L > 0.
  2. Otherwise, if `cbuf_rdreq` is high, decrement the count, saturating at 0.
  3. Otherwise, hold.
- FSM transitions evaluate the registered count:
  - IDLE→RUN when count >= `START_THRESH`.
  - RUN→IDLE when count <= `STOP_THRESH`.
  - RUN→DRAIN on `flush`.
  - IDLE on `flush`: stays IDLE and clears the count to 0.
  - DRAIN→IDLE when count == 0.
- In DRAIN, `tag_cpl` loads are ignored. Reads continue until the count reaches zero, regardless of `STOP_THRESH`.
- Underrun: `rdreq` & `gearbox_ena` & `empty` sets `underrun[i]`. The flag is cleared only by `flush[i]` or reset. If set and clear occur in the same cycle, set wins.
- Arithmetic is unsigned `WIDTH`-bit. No wrap is permitted in either direction.

## Timing
- Reset, asynchronous on `reset_n` low:
  - all states IDLE;
  - `cpld_count` = 0, `underrun` = 0;
  - therefore `gearbox_ena`, `cbuf_rdreq` and `cbuf_rdena` = 0.
- A `tag_cpl` at edge t updates `cpld_count` at t+1. `gearbox_ena` can rise at t+2 at the earliest.
- A count reaching the stop condition at edge t drops `gearbox_ena` at t+1. A read accepted in that intervening cycle still decrements, saturating at 0.
- `flush` in RUN moves the FSM to DRAIN at t+1. `gearbox_ena` stays high throughout the transition.
- `cbuf_rdreq` and `cbuf_rdena` have zero latency from their inputs.
- Reset asserted mid-drain aborts immediately. No read is issued after `reset_n` falls.

## Configuration
- `SONIC_TX_UNDERRUN_EN` defined: underrun detection and the sticky flag are compiled in.
- Not defined: `underrun` is tied to 0, with no flop. All other behaviour is identical.

## Structure
- A shared package `sonic_tx_ctl_pkg` holds:
  - the FSM enum `tx_ready_state_t` {IDLE, RUN, DRAIN};
  - the default threshold and `MAX_QWORDS` constants.
- Sub-module `sonic_tx_ready_ch` implements the per-channel counter, FSM and underrun logic. The top level instantiates it `NUM_CH` times via generate and slices the vector ports.

## Test plan
- Load below threshold: `tag_cpl` with `rdusedqwords`=0x1FF → `cpld_count`=0x1FF, `gearbox_ena` stays 0. Then `tag_cpl` with 0x200 → `gearbox_ena`=1 two cycles after the pulse.
- Run to stop: count 0x200 in RUN, 0x200 consecutive `rdreq` with `empty`=0 → `cpld_count` reaches 0, `gearbox_ena` falls the next cycle, no underflow below 0.
- Simultaneous events: `tag_cpl` together with an accepted read, `rdusedqwords`=0x300 → `cpld_count`=0x2FF. Same with `rdusedqwords`=0 → `cpld_count`=0.
- Clamp: `rdusedqwords`=0x3FFF → `cpld_count`=0x3E00.
- Flush: in RUN with count 0x250, pulse `flush`, then `tag_cpl` with 0x3000 → load ignored, drains to 0, then IDLE. Pulse `flush` in IDLE with count 0x100 → count 0, state remains IDLE.
- Underrun (with `SONIC_TX_UNDERRUN_EN`): `rdreq`=1, `empty`=1 while RUN → `underrun`=1, `cbuf_rdreq`=0, flag stays set until `flush`. Channel 1 activity leaves channel 0 outputs unchanged.
